ahb_matrix_out_stage_2in: RTL and testbench



---
 rtl/ahb_matrix_out_stage_2in.sv | 166 ++++++++++++++++
 tb/tb_ahb_matrix_out_stage_2in.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_matrix_out_stage_2in.sv
// Slave-port output stage of a two-input AHB bus matrix: arbitrates the decoder
// requests (round-robin or fixed priority, with burst/lock hold) and drives one master port.
module ahb_matrix_out_stage_2in #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter bit          FIXED_PRI = 1'b0
) (
    input  logic              HCLK,
    input  logic              HRESETn,

    input  logic              sel_op0,
    input  logic [ADDR_W-1:0] addr_op0,
    input  logic [1:0]        trans_op0,
    input  logic              write_op0,
    input  logic [2:0]        size_op0,
    input  logic [2:0]        burst_op0,
    input  logic [3:0]        prot_op0,
    input  logic              lock_op0,
    input  logic [DATA_W-1:0] wdata_op0,

    input  logic              sel_op1,
    input  logic [ADDR_W-1:0] addr_op1,
    input  logic [1:0]        trans_op1,
    input  logic              write_op1,
    input  logic [2:0]        size_op1,
    input  logic [2:0]        burst_op1,
    input  logic [3:0]        prot_op1,
    input  logic              lock_op1,
    input  logic [DATA_W-1:0] wdata_op1,

    output logic              active_op0,
    output logic              active_op1,

    output logic              HSELM,
    output logic [ADDR_W-1:0] HADDRM,
    output logic [1:0]        HTRANSM,
    output logic              HWRITEM,
    output logic [2:0]        HSIZEM,
    output logic [2:0]        HBURSTM,
    output logic [3:0]        HPROTM,
    output logic              HMASTLOCKM,
    output logic [DATA_W-1:0] HWDATAM,
    output logic              HREADYMUXM,
    input  logic              HREADYOUTM
);

    localparam logic [1:0] TransIdle = 2'b00;

    logic [1:0] addr_port_q, addr_port_d;
    logic [1:0] data_port_q, data_port_d;
    logic       last_port_q, last_port_d;

    logic [1:0] free_grant;
    logic [1:0] next_grant;
    logic       owner_hold;

    // BUSY (01) and SEQ (11) both have trans[0] set: the owner is mid-burst.
    assign owner_hold = (addr_port_q[0] & sel_op0 & (trans_op0[0] | lock_op0)) |
                        (addr_port_q[1] & sel_op1 & (trans_op1[0] | lock_op1));

    always_comb begin
        free_grant = 2'b00;
        if (FIXED_PRI) begin
            if (sel_op0) begin
                free_grant = 2'b01;
            end else if (sel_op1) begin
                free_grant = 2'b10;
            end
        end else begin
            if (sel_op0 && sel_op1) begin
                free_grant = last_port_q ? 2'b01 : 2'b10;
            end else if (sel_op0) begin
                free_grant = 2'b01;
            end else if (sel_op1) begin
                free_grant = 2'b10;
            end
        end
    end

    assign next_grant = owner_hold ? addr_port_q : free_grant;

    always_comb begin
        addr_port_d = addr_port_q;
        data_port_d = data_port_q;
        last_port_d = last_port_q;
        if (HREADYOUTM) begin
            addr_port_d = next_grant;
            if (next_grant != 2'b00) begin
                last_port_d = next_grant[1];
            end
            data_port_d = (HSELM && HTRANSM[1]) ? addr_port_q : 2'b00;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_port_q <= 2'b00;
            data_port_q <= 2'b00;
            last_port_q <= 1'b1;
        end else begin
            addr_port_q <= addr_port_d;
            data_port_q <= data_port_d;
            last_port_q <= last_port_d;
        end
    end

    // Address-phase mux; 11 is unreachable and driven X to make corruption visible.
    always_comb begin
        HSELM      = 1'b0;
        HADDRM     = '0;
        HTRANSM    = TransIdle;
        HWRITEM    = 1'b0;
        HSIZEM     = 3'b000;
        HBURSTM    = 3'b000;
        HPROTM     = 4'b0000;
        HMASTLOCKM = 1'b0;
        unique case (addr_port_q)
            2'b00: ;
            2'b01: begin
                HSELM      = sel_op0;
                HADDRM     = addr_op0;
                HTRANSM    = sel_op0 ? trans_op0 : TransIdle;
                HWRITEM    = write_op0;
                HSIZEM     = size_op0;
                HBURSTM    = burst_op0;
                HPROTM     = prot_op0;
                HMASTLOCKM = lock_op0;
            end
            2'b10: begin
                HSELM      = sel_op1;
                HADDRM     = addr_op1;
                HTRANSM    = sel_op1 ? trans_op1 : TransIdle;
                HWRITEM    = write_op1;
                HSIZEM     = size_op1;
                HBURSTM    = burst_op1;
                HPROTM     = prot_op1;
                HMASTLOCKM = lock_op1;
            end
            default: begin
                HSELM      = 1'bx;
                HADDRM     = 'x;
                HTRANSM    = 2'bxx;
                HWRITEM    = 1'bx;
                HSIZEM     = 3'bxxx;
                HBURSTM    = 3'bxxx;
                HPROTM     = 4'bxxxx;
                HMASTLOCKM = 1'bx;
            end
        endcase
    end

    always_comb begin
        HWDATAM = '0;
        unique case (data_port_q)
            2'b00:   HWDATAM = '0;
            2'b01:   HWDATAM = wdata_op0;
            2'b10:   HWDATAM = wdata_op1;
            default: HWDATAM = 'x;
        endcase
    end

    assign active_op0 = addr_port_q[0];
    assign active_op1 = addr_port_q[1];
    assign HREADYMUXM = HREADYOUTM;

endmodule

// File: tb/tb_ahb_matrix_out_stage_2in.sv
// Bench for ahb_matrix_out_stage_2in: round-robin and fixed-priority instances driven
// by directed and random traffic, checked every cycle against a transaction-level model.
module tb_ahb_matrix_out_stage_2in;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ready = 1'b1;

    logic        sel   [2];
    logic [31:0] addr  [2];
    logic [1:0]  trans [2];
    logic        write [2];
    logic [2:0]  size  [2];
    logic [2:0]  burst [2];
    logic [3:0]  prot  [2];
    logic        lock  [2];
    logic [31:0] wdata [2];

    // Index 0 = round-robin instance, 1 = fixed-priority instance.
    logic        o_act0 [2], o_act1 [2], o_hsel [2], o_hwrite [2], o_hlock [2], o_rdy [2];
    logic [31:0] o_haddr [2], o_hwdata [2];
    logic [1:0]  o_htrans [2];
    logic [2:0]  o_hsize [2], o_hburst [2];
    logic [3:0]  o_hprot [2];

    int n_chk = 0;
    int n_err = 0;

    // Model state: owner of address phase, last winner, data-phase owner (-1 = none).
    int own  [2];
    int last [2];
    int dat  [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ahb_matrix_out_stage_2in #(
            .ADDR_W   (32),
            .DATA_W   (32),
            .FIXED_PRI(g == 1)
        ) u_dut (
            .HCLK      (clk),
            .HRESETn   (rst_n),
            .sel_op0   (sel[0]),
            .addr_op0  (addr[0]),
            .trans_op0 (trans[0]),
            .write_op0 (write[0]),
            .size_op0  (size[0]),
            .burst_op0 (burst[0]),
            .prot_op0  (prot[0]),
            .lock_op0  (lock[0]),
            .wdata_op0 (wdata[0]),
            .sel_op1   (sel[1]),
            .addr_op1  (addr[1]),
            .trans_op1 (trans[1]),
            .write_op1 (write[1]),
            .size_op1  (size[1]),
            .burst_op1 (burst[1]),
            .prot_op1  (prot[1]),
            .lock_op1  (lock[1]),
            .wdata_op1 (wdata[1]),
            .active_op0(o_act0[g]),
            .active_op1(o_act1[g]),
            .HSELM     (o_hsel[g]),
            .HADDRM    (o_haddr[g]),
            .HTRANSM   (o_htrans[g]),
            .HWRITEM   (o_hwrite[g]),
            .HSIZEM    (o_hsize[g]),
            .HBURSTM   (o_hburst[g]),
            .HPROTM    (o_hprot[g]),
            .HMASTLOCKM(o_hlock[g]),
            .HWDATAM   (o_hwdata[g]),
            .HREADYMUXM(o_rdy[g]),
            .HREADYOUTM(ready)
        );
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [14:0] exp_ctrl(input int o);
        if (o < 0) return '0;
        return {sel[o], (sel[o] ? trans[o] : IDLE), write[o], size[o], burst[o], prot[o],
                lock[o]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            own[k]  = -1;
            last[k] = 1;
            dat[k]  = -1;
        end
    endtask

    task automatic model_update(input int k);
        int  o, n;
        bit  issued, hold;
        if (!ready) return;
        o      = own[k];
        issued = (o >= 0) && sel[o] && (trans[o] == NONSEQ || trans[o] == SEQ);
        hold   = (o >= 0) && sel[o] && (trans[o] == BUSY || trans[o] == SEQ || lock[o]);
        if (hold) begin
            n = o;
        end else if (sel[0] && sel[1]) begin
            n = (k == 1) ? 0 : 1 - last[k];
        end else if (sel[0]) begin
            n = 0;
        end else if (sel[1]) begin
            n = 1;
        end else begin
            n = -1;
        end
        if (n >= 0) last[k] = n;
        dat[k] = issued ? o : -1;
        own[k] = n;
    endtask

    task automatic check_dut(input int k);
        string       pfx;
        logic [14:0] got_ctrl;
        pfx      = (k == 0) ? "rr" : "fp";
        got_ctrl = {o_hsel[k], o_htrans[k], o_hwrite[k], o_hsize[k], o_hburst[k], o_hprot[k],
                    o_hlock[k]};
        check_eq({pfx, "_ctrl"}, 64'(got_ctrl), 64'(exp_ctrl(own[k])));
        check_eq({pfx, "_haddr"}, 64'(o_haddr[k]), (own[k] < 0) ? 64'd0 : 64'(addr[own[k]]));
        check_eq({pfx, "_hwdata"}, 64'(o_hwdata[k]), (dat[k] < 0) ? 64'd0 : 64'(wdata[dat[k]]));
        check_eq({pfx, "_active"}, 64'({o_act1[k], o_act0[k]}),
                 64'({own[k] == 1, own[k] == 0}));
        check_eq({pfx, "_hready"}, 64'(o_rdy[k]), 64'(ready));
    endtask

    // Called just after a negedge with inputs already driven.
    task automatic run_cycle();
        #1;
        check_dut(0);
        check_dut(1);
        @(posedge clk);
        if (rst_n) begin
            model_update(0);
            model_update(1);
        end
        @(negedge clk);
    endtask

    task automatic drive(input int i, input logic s, input logic [1:0] t, input logic lk);
        sel[i]   = s;
        trans[i] = t;
        lock[i]  = lk;
        addr[i]  = $urandom;
        write[i] = 1'($urandom_range(1));
        size[i]  = 3'($urandom_range(7));
        burst[i] = 3'($urandom_range(7));
        prot[i]  = 4'($urandom_range(15));
        wdata[i] = $urandom;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_dut(0);
        check_dut(1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        drive(0, 1'b0, IDLE, 1'b0);
        drive(1, 1'b0, IDLE, 1'b0);
        @(negedge clk);
        #1;
        check_dut(0);
        check_dut(1);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset.
        for (int c = 0; c < 5; c++) begin
            drive(0, 1'b0, IDLE, 1'b0);
            drive(1, 1'b0, IDLE, 1'b0);
            run_cycle();
        end

        // Both inputs issue NONSEQ singles continuously.
        for (int c = 0; c < 8; c++) begin
            drive(0, 1'b1, NONSEQ, 1'b0);
            drive(1, 1'b1, NONSEQ, 1'b0);
            run_cycle();
        end

        // Input 0 burst: sole requester on NONSEQ, then SEQ x3 while input 1 waits.
        pulse_reset();
        drive(0, 1'b1, NONSEQ, 1'b0); drive(1, 1'b0, IDLE, 1'b0); run_cycle();
        drive(0, 1'b1, NONSEQ, 1'b0); drive(1, 1'b0, IDLE, 1'b0); run_cycle();
        for (int c = 0; c < 3; c++) begin
            drive(0, 1'b1, SEQ, 1'b0);
            drive(1, 1'b1, NONSEQ, 1'b0);
            run_cycle();
        end
        for (int c = 0; c < 3; c++) begin
            drive(0, 1'b0, IDLE, 1'b0);
            drive(1, 1'b1, NONSEQ, 1'b0);
            run_cycle();
        end

        // Input 1 owns; wait states while input 0 requests, then ready again.
        ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(0, 1'b1, NONSEQ, 1'b0);
            drive(1, 1'b1, NONSEQ, 1'b0);
            run_cycle();
        end
        ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive(0, 1'b1, NONSEQ, 1'b0);
            drive(1, 1'b1, NONSEQ, 1'b0);
            run_cycle();
        end

        // Locked sequence with IDLE gaps from input 0, then lock released.
        pulse_reset();
        for (int c = 0; c < 8; c++) begin
            drive(0, 1'b1, (c % 2 == 0) ? NONSEQ : IDLE, 1'b1);
            drive(1, 1'b1, NONSEQ, 1'b0);
            ready = (c != 4);
            run_cycle();
        end
        ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive(0, 1'b1, NONSEQ, 1'b0);
            drive(1, 1'b1, NONSEQ, 1'b0);
            run_cycle();
        end

        // Reset in the middle of a write data phase.
        drive(0, 1'b1, NONSEQ, 1'b0);
        drive(1, 1'b1, NONSEQ, 1'b0);
        pulse_reset();

        // Random traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 2; i++) begin
                drive(i, ($urandom_range(3) != 0), 2'($urandom_range(3)),
                      ($urandom_range(7) == 0));
            end
            ready = ($urandom_range(4) != 0);
            if ($urandom_range(99) == 0) begin
                pulse_reset();
            end else begin
                run_cycle();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
